// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// instruction-fetch (IF) and load/store (DM) stages. One transaction is in
// flight at a time. Data accesses win ties, but a streak limit on consecutive
// data grants guarantees that a waiting fetch eventually gets through.
module mem_port_arbiter #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  // instruction-fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // load/store requester
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [3:0]        streak_q, streak_d;
  logic              can_arb, dm_wins;

  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              if_gnt_d, dm_gnt_d, if_rvalid_d, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_d, dm_rdata_d;

  // Arbitration waits out any gnt/rvalid pulse so a requester can drop or
  // change its request on the edge where it sees the pulse.
  assign can_arb = !halt && !if_gnt && !dm_gnt && !if_rvalid && !dm_rvalid;
  assign dm_wins = dm_req && (!if_req || (streak_q != STREAK_MAX));
  assign busy    = (state_q != IDLE);

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;

    case (state_q)
      IDLE: begin
        if (can_arb && dm_wins) begin
          owner_d     = OWN_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = ISSUE;
          if (!if_req)                   streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + 4'd1;
        end else if (can_arb && if_req) begin
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          state_d     = ISSUE;
          streak_d    = '0;
        end
      end

      ISSUE: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          if (owner_q == OWN_DM) dm_gnt_d = 1'b1;
          else                   if_gnt_d = 1'b1;
          state_d = mem_we ? IDLE : WAIT;
        end
      end

      WAIT: begin
        if (mem_rvalid) begin
          if (owner_q == OWN_DM) begin
            dm_rdata_d  = mem_rdata;
            dm_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      streak_q  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_gnt    <= if_gnt_d;
      dm_gnt    <= dm_gnt_d;
      if_rvalid <= if_rvalid_d;
      dm_rvalid <= dm_rvalid_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 ns after a rising
// edge; outputs are sampled at the same point, reflecting that edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              halt;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt, dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready, mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst(rst), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse exclusivity between owners and between gnt/rvalid of one owner.
  always @(negedge clk) begin
    if (!rst)
      check("excl", {if_gnt && dm_gnt, if_rvalid && dm_rvalid,
                     if_gnt && if_rvalid, dm_gnt && dm_rvalid}, 4'b0000);
  end

  // Serve one transaction: bounded wait for mem_req, accept it, and return
  // read data when it is a read. Reports whether DM owned it (by address).
  task automatic serve(input logic [ADDR_W-1:0] dm_a, output bit was_dm);
    bit is_rd;
    for (int i = 0; i < 10 && !mem_req; i++) step();
    check("serve_req", mem_req, 1'b1);
    was_dm    = (mem_addr == dm_a);
    is_rd     = !mem_we;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("serve_gnt", {if_gnt, dm_gnt}, was_dm ? 2'b01 : 2'b10);
    if (is_rd) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_0000;
      step();
      mem_rvalid = 1'b0;
    end
  endtask

  bit got_dm;
  bit exp_dm [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; halt = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    check("rst_outs", {busy, mem_req, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid}, '0);
    check("rst_buses", {if_rdata, dm_rdata}, '0);
    step(); step();
    rst = 1'b0;

    // ---- single fetch ----
    if_req = 1'b1; if_addr = 10'h005;
    step();
    check("f_req", {mem_req, mem_we, busy, if_gnt}, 4'b1010);
    check("f_addr", mem_addr, 10'h005);
    mem_ready = 1'b1;
    step();
    check("f_gnt", {if_gnt, mem_req, dm_gnt}, 3'b100);
    if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2801_000A;
    step();
    check("f_rvalid", {if_rvalid, if_gnt, dm_rvalid}, 3'b100);
    check("f_rdata", if_rdata, 32'h2801_000A);
    mem_rvalid = 1'b0;
    step();
    check("f_idle", {busy, if_rvalid, mem_req}, 3'b000);
    check("f_hold", if_rdata, 32'h2801_000A);

    // ---- store with memory stall ----
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h3FF; dm_wdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 4; c++) begin
      step();
      check("st_stable", {mem_req, mem_we, dm_gnt, busy}, 4'b1101);
      check("st_addr", mem_addr, 10'h3FF);
      check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      if (c == 3) mem_ready = 1'b1;
    end
    step();
    check("st_gnt", {dm_gnt, mem_req, dm_rvalid}, 3'b100);
    dm_req = 1'b0; mem_ready = 1'b0;
    step();
    check("st_done", {dm_gnt, dm_rvalid, busy}, 3'b000);
    step();
    check("st_no_rv", dm_rvalid, 1'b0);

    // ---- simultaneous requests ----
    if_req = 1'b1; if_addr = 10'h010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h020;
    step();
    check("sim_dm_first", {mem_req, mem_we}, 2'b10);
    check("sim_dm_addr", mem_addr, 10'h020);
    mem_ready = 1'b1;
    step();
    check("sim_dm_gnt", {if_gnt, dm_gnt}, 2'b01);
    dm_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    check("sim_dm_rv", {if_rvalid, dm_rvalid, mem_req}, 3'b010);
    check("sim_dm_rdata", dm_rdata, 32'h1111_1111);
    mem_rvalid = 1'b0;
    step();
    check("sim_gap", mem_req, 1'b0);
    step();
    check("sim_if_req", mem_req, 1'b1);
    check("sim_if_addr", mem_addr, 10'h010);
    mem_ready = 1'b1;
    step();
    check("sim_if_gnt", {if_gnt, dm_gnt}, 2'b10);
    if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    step();
    check("sim_if_rv", {if_rvalid, dm_rvalid}, 2'b10);
    check("sim_if_rdata", if_rdata, 32'h2222_2222);
    check("sim_dm_keep", dm_rdata, 32'h1111_1111);
    mem_rvalid = 1'b0;
    step();

    // ---- starvation limit: D D D D I D D D D I D ----
    if_req = 1'b1; if_addr = 10'h030;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h040; dm_wdata = 32'h0000_0040;
    for (int k = 0; k < 11; k++) begin
      serve(10'h040, got_dm);
      check($sformatf("starve_%0d", k), got_dm, exp_dm[k]);
    end
    if_req = 1'b0; dm_req = 1'b0;
    step(); step();
    check("starve_idle", {busy, mem_req}, 2'b00);

    // ---- halt during WAIT of a load ----
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h050;
    step();
    mem_ready = 1'b1;
    step();
    check("h_gnt", dm_gnt, 1'b1);
    dm_req = 1'b0; mem_ready = 1'b0; halt = 1'b1;
    if_req = 1'b1; if_addr = 10'h060;
    step();
    check("h_wait", {busy, mem_req}, 2'b10);
    mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
    step();
    check("h_rv", dm_rvalid, 1'b1);
    check("h_rdata", dm_rdata, 32'h3333_3333);
    mem_rvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      check("h_frozen", {mem_req, busy, if_gnt}, 3'b000);
    end
    halt = 1'b0;
    step();
    check("h_resume", mem_req, 1'b1);
    check("h_resume_addr", mem_addr, 10'h060);
    mem_ready = 1'b1;
    step();
    if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h6666_6666;
    step();
    check("h_if_rv", {if_rvalid, if_rdata}, {1'b1, 32'h6666_6666});
    mem_rvalid = 1'b0;
    step();

    // ---- reset mid-WAIT ----
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h070;
    step();
    mem_ready = 1'b1;
    step();
    check("r_in_wait", {dm_gnt, busy}, 2'b11);
    dm_req = 1'b0; mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("r_outs", {busy, mem_req, mem_we, if_gnt, dm_gnt, if_rvalid, dm_rvalid}, '0);
    check("r_buses", {if_rdata, dm_rdata}, '0);
    check("r_mem_bus", {mem_addr, mem_wdata}, '0);
    step();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
    step();
    check("r_no_rv", {dm_rvalid, if_rvalid, busy}, 3'b000);
    check("r_rdata", dm_rdata, 32'h0);
    mem_rvalid = 1'b0;
    if_req = 1'b1; if_addr = 10'h080;
    step();
    check("r_new_req", {mem_req, mem_we}, 2'b10);
    check("r_new_addr", mem_addr, 10'h080);
    mem_ready = 1'b1;
    step();
    check("r_new_gnt", if_gnt, 1'b1);
    if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h8080_8080;
    step();
    check("r_new_rv", {if_rvalid, if_rdata}, {1'b1, 32'h8080_8080});
    mem_rvalid = 1'b0;
    step();
    check("r_end_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
